jk_reg_array: RTL
=================

# jk_reg_array

Parametrised bank of WIDTH JK flip-flops sharing one clock. Each bit keeps classic JK semantics (hold/reset/set/toggle), and the bank adds mode-selected parallel load, shift and rotate, a clock enable, a registered change flag and an optional saturating toggle-event counter. It is the general-purpose successor to the single-bit JK flip-flop, for control registers, flag banks and small shift/rotate structures.

## Interface

Parameters:
- WIDTH, 8: number of flip-flops, ≥1.
- CNT_W, 16: toggle counter width, ≥1. Used only when JKR_TOGGLE_CNT_EN is defined.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into q on reset.

Ports:
- clk  input  1  clock; all state updates on the posedge.
- reset  input  1  synchronous, active-high reset. Sampled on the clk posedge; overrides all other inputs.
- en  input  1  clock enable. When low, all state holds.
- mode  input  2  00 JK, 01 parallel load, 10 shift left, 11 rotate left.
- j  input  WIDTH  per-bit J (JK mode only).
- k  input  WIDTH  per-bit K (JK mode only).
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input; enters at bit 0 in shift mode.
- q  output  WIDTH  register state.
- sout  output  1  equals q[WIDTH-1]; driven combinationally from the register, no added logic.
- changed  output  1  registered; high for one cycle when q's latest update altered at least one bit.
- toggle_cnt  output  CNT_W  saturating count of flipped bits. Present only with JKR_TOGGLE_CNT_EN.

## Operation

Reset values:
- q = RESET_VAL, changed = 0, toggle_cnt = 0.

Priority at each posedge: reset > en = 0 > mode.

- **en = 0:** q and toggle_cnt hold; changed <= 0.
- **mode 00 (JK),** per bit i, by {j[i],k[i]}:
  - 00: hold
  - 01: 0
  - 10: 1
  - 11: ~q[i]
- **mode 01 (load):** q <= d. j, k and sin are ignored.
- **mode 10 (shift):** q <= {q[WIDTH-2:0], sin}. For WIDTH = 1, q <= sin.
- **mode 11 (rotate):** q <= {q[WIDTH-2:0], q[WIDTH-1]}. For WIDTH = 1, q holds.
- **Next-state signal:** nq is the combinational next value. changed <= (nq != q) whenever en = 1 and reset = 0.
- **Counter:** toggle_cnt <= min(toggle_cnt + popcount(q ^ nq), 2^CNT_W − 1).
  - popcount is computed at width $clog2(WIDTH+1); the sum is formed at CNT_W+1 bits, then saturated.
  - Once at max, the counter stays there until reset; it does not wrap.
- **Unused inputs:** inputs not used by the current mode have no effect.
- **No X-resolution:** unknown j/k/d/sin values propagate to q; the block does not resolve them.

## Timing

- Latency of one cycle from inputs to q.
- changed and toggle_cnt update on the same edge as q, so they describe the q value now visible.
- **Reset mid-operation:** reset asserted on any edge yields q = RESET_VAL, changed = 0, toggle_cnt = 0 on that edge, regardless of en or mode.
  - The reset-to-RESET_VAL transition is not counted and does not raise changed.
- **Release from reset:** the first edge with reset = 0 behaves normally.
- **Mode switching:** mode may change every cycle; there is no internal state beyond q, changed and toggle_cnt.

## Configuration

- **JKR_TOGGLE_CNT_EN defined:** the toggle_cnt port, its popcount logic and the saturating counter are present.
- **JKR_TOGGLE_CNT_EN undefined:**
  - The port and its logic are removed, and CNT_W is ignored.
  - Every other behaviour is identical in both builds.

## Test plan

All scenarios use WIDTH = 8, RESET_VAL = 00.

1. **Reset priority:** reset = 1 for 2 cycles with en = 1, mode = 00, j = k = FF → q = 00, changed = 0, toggle_cnt = 0.
2. **JK mode:** from q = 00:
   - j = 0F, k = 00 → q = 0F, changed = 1.
   - j = k = FF → q = F0.
   - j = 00, k = F0 → q = 00.
   - j = k = 00 → q = 00, changed = 0.
3. **Load, shift, rotate:**
   - Load d = A5 → q = A5, sout = 1.
   - Shift with sin = 1 → q = 4B, sout = 0.
   - Rotate → q = 96.
   - Rotate again → q = 2D.
4. **Enable low:** en = 0, mode = 01, d = FF for 3 cycles → q holds its prior value and changed = 0 each cycle. Then en = 1 → q = FF next edge.
5. **Saturating counter** (CNT_W = 4, macro defined): from q = 00, toggle j = k = FF → toggle_cnt = 8, then saturates at 15 on the second toggle. Further toggles keep it at 15; reset clears it to 0.
6. **Reset mid-shift:** load 81, shift twice, then assert reset with mode = 10, en = 1 → q = 00, changed = 0 on that edge.

Source files
------------

// File: rtl/jk_reg_array.sv
// jk_reg_array: bank of JK flip-flops with load/shift/rotate, enable, change flag
// and, with JKR_TOGGLE_CNT_EN defined, a saturating toggle-event counter.
module jk_reg_array #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
`ifdef JKR_TOGGLE_CNT_EN
  output logic [CNT_W-1:0] toggle_cnt,
`endif
  output logic             changed
);
  logic [WIDTH-1:0] nq, shl, rol;
  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("jk_reg_array: WIDTH and CNT_W must be at least 1");
  end
  if (WIDTH == 1) begin : g_w1
    assign shl = sin;
    assign rol = q;
  end else begin : g_wn
    assign shl = {q[WIDTH-2:0], sin};
    assign rol = {q[WIDTH-2:0], q[WIDTH-1]};
  end
  always_comb
    nq = mode == 2'b00 ? (j & ~q) | (~k & q) :
         mode == 2'b01 ? d :
         mode == 2'b10 ? shl : rol;
  assign sout = q[WIDTH-1];
  always_ff @(posedge clk)
    if (reset) begin
      q       <= RESET_VAL;
      changed <= 1'b0;
    end else if (!en) begin
      changed <= 1'b0;
    end else begin
      q       <= nq;
      changed <= nq != q;
    end
`ifdef JKR_TOGGLE_CNT_EN
  localparam int PW = $clog2(WIDTH + 1);
  logic [PW-1:0]  pc;
  logic [CNT_W:0] sum;
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + PW'(q[i] ^ nq[i]);
    sum = {1'b0, toggle_cnt} + (CNT_W + 1)'(pc);
  end
  always_ff @(posedge clk)
    if (reset) toggle_cnt <= '0;
    else if (en) toggle_cnt <= sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
`endif
endmodule
